// File: rtl/mux_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter_pkg
// Shared definitions for the round-robin packet arbiter:
//   - arb_state_t : arbitration FSM states (idle / locked to in0 / in1)
//   - cnt_width() : width of the per-packet beat counter for a given limit
// ---------------------------------------------------------------------------
package mux_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    // The counter must be able to hold MAX_BEATS itself, hence +1.
    function automatic int cnt_width(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// ---------------------------------------------------------------------------
// mux
// Plain 2:1 WIDTH-bit combinational multiplexer used as the shared datapath.
// Ports:
//   in0, in1 : data inputs
//   sel      : 0 selects in0, 1 selects in1
//   out      : selected data
// ---------------------------------------------------------------------------
module mux #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign out[gi] = sel ? in1[gi] : in0[gi];
        end
    endgenerate

endmodule

// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin arbiter sharing one 2:1 mux between two valid/ready packet
// producers. The grant is locked for a whole packet (up to MAX_BEATS beats,
// after which it is force-released) and the selected beat is captured in a
// registered output stage.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   in{0,1}_valid/_data/_last        : requester beats
//   in{0,1}_ready                    : beat accepted when valid && ready
//   out_valid/_data/_last/_sel       : registered output beat and its source
//   out_ready                        : consumer accepts the output beat
//   err_overrun                      : one-cycle pulse with a forced-release beat
// ---------------------------------------------------------------------------
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int MAX_BEATS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_sel,
    input  logic             out_ready,
    output logic             err_overrun
);

    localparam int CW = cnt_width(MAX_BEATS);

    arb_state_t       state_reg, state_next;
    logic             last_grant_reg, last_grant_next;
    logic [CW-1:0]    beat_cnt_reg, beat_cnt_next;

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_last_reg;
    logic             out_sel_reg;
    logic             err_overrun_reg;

    logic             load;
    logic             winner;
    logic             sel;
    logic             sel_valid;
    logic             sel_last;
    logic             accept;
    logic             forced;
    logic [CW-1:0]    beat_cnt_inc;
    logic [WIDTH-1:0] mux_out;

    // Output stage can take a new beat when empty or being drained this cycle.
    assign load = !out_valid_reg || out_ready;

    // Idle winner: sole valid requester, or the one not granted last on a tie.
    always_comb begin
        winner = 1'b0;
        if (in0_valid && in1_valid) begin
            winner = ~last_grant_reg;
        end else if (in1_valid) begin
            winner = 1'b1;
        end
    end

    always_comb begin
        sel = winner;
        case (state_reg)
            ST_LOCK0: sel = 1'b0;
            ST_LOCK1: sel = 1'b1;
            default:  sel = winner;
        endcase
    end

    // In IDLE only a valid winner sees ready; in a lock the owner sees ready
    // regardless of its valid and the other side is held off.
    always_comb begin
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        case (state_reg)
            ST_LOCK0: in0_ready = load;
            ST_LOCK1: in1_ready = load;
            default: begin
                in0_ready = load && in0_valid && !winner;
                in1_ready = load && in1_valid &&  winner;
            end
        endcase
    end

    assign sel_valid    = sel ? in1_valid : in0_valid;
    assign sel_last     = sel ? in1_last  : in0_last;
    assign accept       = sel_valid && load;
    assign beat_cnt_inc = beat_cnt_reg + CW'(1);

    // A locked packet reaching its beat limit without last is cut short.
    assign forced = accept && (state_reg != ST_IDLE) && !sel_last
                    && (beat_cnt_inc == CW'(MAX_BEATS));

    mux #(
        .WIDTH (WIDTH)
    ) u_mux (
        .in0 (in0_data),
        .in1 (in1_data),
        .sel (sel),
        .out (mux_out)
    );

    // Arbitration FSM: next-state logic.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        beat_cnt_next   = beat_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (sel_last) begin
                        last_grant_next = sel;
                    end else begin
                        state_next    = sel ? ST_LOCK1 : ST_LOCK0;
                        beat_cnt_next = CW'(1);
                    end
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                if (accept) begin
                    if (sel_last || forced) begin
                        state_next      = ST_IDLE;
                        last_grant_next = sel;
                        beat_cnt_next   = '0;
                    end else begin
                        beat_cnt_next = beat_cnt_inc;
                    end
                end
            end
            default: begin
                state_next    = ST_IDLE;
                beat_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
            beat_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            beat_cnt_reg   <= beat_cnt_next;
        end
    end

    // Registered output stage; payload holds when no beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            out_last_reg    <= 1'b0;
            out_sel_reg     <= 1'b0;
            err_overrun_reg <= 1'b0;
        end else begin
            err_overrun_reg <= forced;
            if (load) begin
                out_valid_reg <= accept;
            end
            if (accept) begin
                out_data_reg <= mux_out;
                out_last_reg <= sel_last || forced;
                out_sel_reg  <= sel;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;
    assign out_last    = out_last_reg;
    assign out_sel     = out_sel_reg;
    assign err_overrun = err_overrun_reg;

endmodule
